alvio_write_ctrl: RTL and testbench

Write-port controller for the active-list violation RAM: arbitrates its single write port among NUM_REQ violation/exception reporters and owns the clear sequencer that zeroes the RAM after reset or on request. Sits between the LSU/execute violation sources and the RAM's `addr0wr_i`/`data0wr_i`/`we0_i` port. Commit-side reads are untouched. `ready_o` gates commit and dispatch until the RAM contents are valid.

---
 rtl/alvio_write_ctrl_pkg.sv | 19 +
 rtl/alvio_write_ctrl_if.sv | 26 ++
 rtl/alvio_write_ctrl_rr_arbiter.sv | 34 +++
 rtl/alvio_write_ctrl.sv | 107 ++++++++++
 tb/tb_alvio_write_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/alvio_write_ctrl_pkg.sv
// Shared types and default geometry for the active-list violation RAM write controller.
package alvio_write_ctrl_pkg;

  localparam int DEPTH   = 16;
  localparam int INDEX   = 4;
  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 2;

  typedef enum logic {
    ALVIO_CLEAR = 1'b0,
    ALVIO_RUN   = 1'b1
  } alvio_state_e;

  // Round-robin pointer width; a single requester still needs a 1-bit pointer.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alvio_write_ctrl_if.sv
// Requester write bus and RAM write port of the violation RAM controller.
interface alvio_write_ctrl_if
  import alvio_write_ctrl_pkg::*;
#(
  parameter int NUM_REQ = alvio_write_ctrl_pkg::NUM_REQ,
  parameter int INDEX   = alvio_write_ctrl_pkg::INDEX,
  parameter int WIDTH   = alvio_write_ctrl_pkg::WIDTH
);
  logic [NUM_REQ-1:0]            reqValid_i;
  logic [NUM_REQ-1:0][INDEX-1:0] reqAddr_i;
  logic [NUM_REQ-1:0][WIDTH-1:0] reqData_i;
  logic [NUM_REQ-1:0]            reqReady_o;
  logic                          we_o;
  logic [INDEX-1:0]              addrWr_o;
  logic [WIDTH-1:0]              dataWr_o;

  modport slave (
    input  reqValid_i, reqAddr_i, reqData_i,
    output reqReady_o, we_o, addrWr_o, dataWr_o
  );

  modport master (
    output reqValid_i, reqAddr_i, reqData_i,
    input  reqReady_o, we_o, addrWr_o, dataWr_o
  );
endinterface

// File: rtl/alvio_write_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after i_ptr, plus the
// pointer value that follows the winner.
module rr_arbiter
  import alvio_write_ctrl_pkg::*;
#(
  parameter int NUM_REQ = alvio_write_ctrl_pkg::NUM_REQ,
  parameter int PW      = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PW-1:0]      o_nxt_ptr
);

  logic [PW-1:0] w_win;
  logic [PW-1:0] w_idx;

  // Scan from the farthest offset down so the closest valid one wins last.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = PW'((int'(i_ptr) + i) % NUM_REQ);
      if (i_req[w_idx]) w_win = w_idx;
    end
  end

  always_comb begin
    o_gnt = '0;
    if (|i_req) o_gnt[w_win] = 1'b1;
    o_nxt_ptr = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
  end

endmodule

// File: rtl/alvio_write_ctrl.sv
// Write-port owner for the active-list violation RAM: post-reset/requested clear sweep,
// then round-robin arbitration with same-address merging.
module alvio_write_ctrl
  import alvio_write_ctrl_pkg::*;
#(
  parameter int DEPTH   = alvio_write_ctrl_pkg::DEPTH,
  parameter int INDEX   = alvio_write_ctrl_pkg::INDEX,
  parameter int WIDTH   = alvio_write_ctrl_pkg::WIDTH,
  parameter int NUM_REQ = alvio_write_ctrl_pkg::NUM_REQ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clearReq_i,
  alvio_write_ctrl_if.slave  bus,
  output logic               ready_o,
  output logic               clearing_o
);

  localparam int PW = ptr_w(NUM_REQ);

  alvio_state_e      r_state, w_state_nxt;
  logic [INDEX-1:0]  r_cnt, w_cnt_nxt;
  logic [PW-1:0]     r_ptr, w_ptr_nxt;
  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [PW-1:0]      w_arb_nxt_ptr;
  logic [INDEX-1:0]   w_win_addr;
  logic [NUM_REQ-1:0] w_merge;
  logic [WIDTH-1:0]   w_merge_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .i_req     (bus.reqValid_i),
    .i_ptr     (r_ptr),
    .o_gnt     (w_arb_gnt),
    .o_nxt_ptr (w_arb_nxt_ptr)
  );

  // Every valid requester aimed at the winner's entry rides along in the same write.
  always_comb begin
    w_win_addr   = '0;
    w_merge      = '0;
    w_merge_data = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (w_arb_gnt[k]) w_win_addr = w_win_addr | bus.reqAddr_i[k];
    for (int j = 0; j < NUM_REQ; j++) begin
      if (bus.reqValid_i[j] && (bus.reqAddr_i[j] == w_win_addr)) begin
        w_merge[j]   = 1'b1;
        w_merge_data = w_merge_data | bus.reqData_i[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ALVIO_CLEAR;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Outputs are forced quiet while reset is held, whatever the registered state.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_ptr_nxt      = r_ptr;
    bus.we_o       = 1'b0;
    bus.addrWr_o   = '0;
    bus.dataWr_o   = '0;
    bus.reqReady_o = '0;
    if (!reset) begin
      case (r_state)
        ALVIO_CLEAR: begin
          bus.we_o     = 1'b1;
          bus.addrWr_o = r_cnt;
          if (clearReq_i) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == INDEX'(DEPTH - 1)) begin
            w_state_nxt = ALVIO_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ALVIO_RUN: begin
          if (clearReq_i) begin
            w_state_nxt = ALVIO_CLEAR;
            w_cnt_nxt   = '0;
          end else if (|w_arb_gnt) begin
            bus.we_o       = 1'b1;
            bus.addrWr_o   = w_win_addr;
            bus.dataWr_o   = w_merge_data;
            bus.reqReady_o = w_merge;
            w_ptr_nxt      = w_arb_nxt_ptr;
          end
        end
        default: w_state_nxt = ALVIO_CLEAR;
      endcase
    end
  end

  assign ready_o    = !reset && (r_state == ALVIO_RUN);
  assign clearing_o = !reset && (r_state == ALVIO_CLEAR);

endmodule

// File: tb/tb_alvio_write_ctrl.sv
// Scoreboarded bench for alvio_write_ctrl: clear sweeps, RR arbitration, merging, restarts.
module tb_alvio_write_ctrl;
  import alvio_write_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clearReq_i = 1'b0;
  logic ready_o, clearing_o;

  alvio_write_ctrl_if #(.NUM_REQ(NUM_REQ), .INDEX(INDEX), .WIDTH(WIDTH)) bus ();

  alvio_write_ctrl #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .clearReq_i (clearReq_i),
    .bus        (bus),
    .ready_o    (ready_o),
    .clearing_o (clearing_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic               we;
    logic [INDEX-1:0]   addr;
    logic [WIDTH-1:0]   data;
    logic [NUM_REQ-1:0] rdy;
    logic               ready;
    logic               clearing;
  } obs_t;

  obs_t sb[$];
  int errors = 0;
  int checks = 0;

  function automatic obs_t mk(input logic we, input logic [INDEX-1:0] a, input logic [WIDTH-1:0] d,
                              input logic [NUM_REQ-1:0] r, input logic rd, input logic cl);
    obs_t o;
    o.we = we; o.addr = a; o.data = d; o.rdy = r; o.ready = rd; o.clearing = cl;
    return o;
  endfunction

  // Address/data only carry meaning while a write is issued.
  function automatic obs_t sample();
    obs_t o;
    o.we = bus.we_o;
    o.addr = bus.we_o ? bus.addrWr_o : '0;
    o.data = bus.we_o ? bus.dataWr_o : '0;
    o.rdy = bus.reqReady_o;
    o.ready = ready_o;
    o.clearing = clearing_o;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [INDEX-1:0] a0, input logic [WIDTH-1:0] d0,
                         input logic [INDEX-1:0] a1, input logic [WIDTH-1:0] d1);
    bus.reqValid_i = v;
    bus.reqAddr_i[0] = a0; bus.reqData_i[0] = d0;
    bus.reqAddr_i[1] = a1; bus.reqData_i[1] = d1;
  endtask

  task automatic test_reset();
    obs_t a, e;
    for (int i = 0; i < 3; i++) begin
      tick();
      reset = 1'b1; clearReq_i = 1'b0; set_req(2'b00, 0, 0, 0, 0);
      sb.push_back(mk(0, 0, 0, 2'b00, 0, 0));
      @(negedge clk); a = sample(); e = sb.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL reset_hold[%0d]: got %h want %h", i, a, e); end
    end
    for (int i = 0; i <= DEPTH; i++) begin
      tick();
      reset = 1'b0;
      if (i < DEPTH) sb.push_back(mk(1, INDEX'(i), 0, 2'b00, 0, 1));
      else           sb.push_back(mk(0, 0, 0, 2'b00, 1, 0));
      @(negedge clk); a = sample(); e = sb.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL reset_sweep[%0d]: got %h want %h", i, a, e); end
    end
  endtask

  task automatic test_single();
    obs_t a, e;
    tick();
    set_req(2'b01, 4'd5, 8'h04, 4'd0, 8'h00);
    sb.push_back(mk(1, 4'd5, 8'h04, 2'b01, 1, 0));
    @(negedge clk); a = sample(); e = sb.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL single_grant: got %h want %h", a, e); end
    // Pointer moved to 1, so requester 1 wins a two-way contest.
    tick();
    set_req(2'b11, 4'd3, 8'h11, 4'd7, 8'h22);
    sb.push_back(mk(1, 4'd7, 8'h22, 2'b10, 1, 0));
    @(negedge clk); a = sample(); e = sb.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL single_ptr_adv: got %h want %h", a, e); end
  endtask

  task automatic test_contention();
    obs_t a, e;
    for (int i = 0; i < 4; i++) begin
      tick();
      set_req(2'b11, 4'd3, 8'h01, 4'd7, 8'h02);
      if (i % 2 == 0) sb.push_back(mk(1, 4'd3, 8'h01, 2'b01, 1, 0));
      else            sb.push_back(mk(1, 4'd7, 8'h02, 2'b10, 1, 0));
      @(negedge clk); a = sample(); e = sb.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL contention[%0d]: got %h want %h", i, a, e); end
    end
  endtask

  task automatic test_merge();
    obs_t a, e;
    tick();
    set_req(2'b11, 4'd9, 8'h01, 4'd9, 8'h10);
    sb.push_back(mk(1, 4'd9, 8'h11, 2'b11, 1, 0));
    @(negedge clk); a = sample(); e = sb.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL merge_write: got %h want %h", a, e); end
    tick();
    set_req(2'b00, 4'd0, 8'h00, 4'd0, 8'h00);
    sb.push_back(mk(0, 0, 0, 2'b00, 1, 0));
    @(negedge clk); a = sample(); e = sb.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL merge_idle: got %h want %h", a, e); end
    // Winner was 0, so pointer sits at 1 across the idle cycle.
    tick();
    set_req(2'b11, 4'd2, 8'h05, 4'd4, 8'h06);
    sb.push_back(mk(1, 4'd4, 8'h06, 2'b10, 1, 0));
    @(negedge clk); a = sample(); e = sb.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL merge_ptr_hold: got %h want %h", a, e); end
  endtask

  task automatic test_clear_run();
    obs_t a, e;
    tick();
    clearReq_i = 1'b1;
    set_req(2'b01, 4'd6, 8'h02, 4'd0, 8'h00);
    sb.push_back(mk(0, 0, 0, 2'b00, 1, 0));
    @(negedge clk); a = sample(); e = sb.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL clear_run_req: got %h want %h", a, e); end
    for (int i = 0; i <= DEPTH; i++) begin
      tick();
      clearReq_i = 1'b0;
      if (i < DEPTH) sb.push_back(mk(1, INDEX'(i), 0, 2'b00, 0, 1));
      else           sb.push_back(mk(1, 4'd6, 8'h02, 2'b01, 1, 0));
      @(negedge clk); a = sample(); e = sb.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL clear_run_sweep[%0d]: got %h want %h", i, a, e); end
    end
  endtask

  task automatic test_clear_restart();
    obs_t a, e;
    tick();
    clearReq_i = 1'b1;
    set_req(2'b00, 0, 0, 0, 0);
    sb.push_back(mk(0, 0, 0, 2'b00, 1, 0));
    @(negedge clk); a = sample(); e = sb.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL restart_req: got %h want %h", a, e); end
    for (int i = 0; i <= 10; i++) begin
      tick();
      clearReq_i = (i == 10);
      sb.push_back(mk(1, INDEX'(i), 0, 2'b00, 0, 1));
      @(negedge clk); a = sample(); e = sb.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL restart_pre[%0d]: got %h want %h", i, a, e); end
    end
    for (int i = 0; i <= DEPTH; i++) begin
      tick();
      clearReq_i = 1'b0;
      if (i < DEPTH) sb.push_back(mk(1, INDEX'(i), 0, 2'b00, 0, 1));
      else           sb.push_back(mk(0, 0, 0, 2'b00, 1, 0));
      @(negedge clk); a = sample(); e = sb.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL restart_sweep[%0d]: got %h want %h", i, a, e); end
    end
  endtask

  task automatic test_reset_midsweep();
    obs_t a, e;
    tick();
    clearReq_i = 1'b1;
    sb.push_back(mk(0, 0, 0, 2'b00, 1, 0));
    @(negedge clk); a = sample(); e = sb.pop_front(); checks++;
    if (a !== e) begin errors++; $display("FAIL rstmid_req: got %h want %h", a, e); end
    for (int i = 0; i <= 6; i++) begin
      tick();
      clearReq_i = 1'b0;
      reset = (i == 6);
      if (i < 6) sb.push_back(mk(1, INDEX'(i), 0, 2'b00, 0, 1));
      else       sb.push_back(mk(0, 0, 0, 2'b00, 0, 0));
      @(negedge clk); a = sample(); e = sb.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL rstmid_pre[%0d]: got %h want %h", i, a, e); end
    end
    for (int i = 0; i <= DEPTH; i++) begin
      tick();
      reset = 1'b0;
      if (i < DEPTH) sb.push_back(mk(1, INDEX'(i), 0, 2'b00, 0, 1));
      else           sb.push_back(mk(0, 0, 0, 2'b00, 1, 0));
      @(negedge clk); a = sample(); e = sb.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL rstmid_sweep[%0d]: got %h want %h", i, a, e); end
    end
  endtask

  initial begin
    set_req(2'b00, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_contention();
    test_merge();
    test_clear_run();
    test_clear_restart();
    test_reset_midsweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
